// File: rtl/ring_matvec.sv
// Systolic-ring matrix-vector engine: N PEs each hold one x element and one accumulator,
// consuming one matrix diagonal per accepted beat while the x ring rotates by one lane.
module ring_matvec #(
   parameter int N      = 4,
   parameter int W      = 16,
   parameter int ACC_W  = 2*W+$clog2(N),
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [N*W-1:0]     x_init,
   input  logic               a_valid,
   input  logic [N*W-1:0]     a,
   output logic               a_ready,
   output logic               busy,
   output logic               done,
   output logic [N*ACC_W-1:0] y
);

   localparam int KW = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [W-1:0]       xr_q   [N];
   logic [ACC_W-1:0]   acc_q  [N];
   logic [ACC_W-1:0]   acc_d  [N];
   logic [2*W-1:0]     prod   [N];
   logic [KW-1:0]      k_q;
   logic [N*ACC_W-1:0] y_q;
   logic               aReady_q;
   logic               busy_q;
   logic               done_q;

   logic beatAccepted;
   assign beatAccepted = (state_q == RUN) && a_valid;

   // Operands are widened to 2W first so the low 2W bits of the product are exact in both modes.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         prod[i]  = '0;
         acc_d[i] = acc_q[i];
         if (SIGNED) begin
            prod[i]  = $signed({{W{a[i*W+W-1]}}, a[i*W +: W]})
                     * $signed({{W{xr_q[i][W-1]}}, xr_q[i]});
            acc_d[i] = acc_q[i] + {{(ACC_W-2*W){prod[i][2*W-1]}}, prod[i]};
         end else begin
            prod[i]  = {{W{1'b0}}, a[i*W +: W]} * {{W{1'b0}}, xr_q[i]};
            acc_d[i] = acc_q[i] + {{(ACC_W-2*W){1'b0}}, prod[i]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         y_q      <= '0;
         aReady_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            xr_q[i]  <= '0;
            acc_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load) begin
                  state_q  <= RUN;
                  k_q      <= '0;
                  aReady_q <= 1'b1;
                  busy_q   <= 1'b1;
                  for (int i = 0; i < N; i++) begin
                     xr_q[i]  <= x_init[i*W +: W];
                     acc_q[i] <= '0;
                  end
               end
            end
            RUN: begin
               if (beatAccepted) begin
                  k_q <= k_q + 1'b1;
                  for (int i = 0; i < N; i++) begin
                     acc_q[i] <= acc_d[i];
                     xr_q[i]  <= xr_q[(i+1) % N];
                  end
                  if (k_q == KW'(N-1)) begin
                     state_q  <= DONE;
                     aReady_q <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               for (int i = 0; i < N; i++) begin
                  y_q[i*ACC_W +: ACC_W] <= acc_q[i];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_ready = aReady_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign y       = y_q;

endmodule

// File: tb/tb_ring_matvec.sv
// Directed bench for ring_matvec: a signed and an unsigned instance share one stimulus stream,
// and every result is compared against hand-computed dot products.
module tb_ring_matvec;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int ACC_W = 2*W+$clog2(N);

   typedef logic [N*W-1:0] beat_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               load;
   logic               a_valid;
   beat_t              x_init;
   beat_t              a;
   logic               a_readyS, busyS, doneS;
   logic               a_readyU, busyU, doneU;
   logic [N*ACC_W-1:0] yS, yU;

   int assertCount = 0;
   int failCount   = 0;

   ring_matvec #(.N(N), .W(W), .ACC_W(ACC_W), .SIGNED(1'b1)) dutS (
      .clk(clk), .reset(reset), .load(load), .x_init(x_init), .a_valid(a_valid), .a(a),
      .a_ready(a_readyS), .busy(busyS), .done(doneS), .y(yS)
   );

   ring_matvec #(.N(N), .W(W), .ACC_W(ACC_W), .SIGNED(1'b0)) dutU (
      .clk(clk), .reset(reset), .load(load), .x_init(x_init), .a_valid(a_valid), .a(a),
      .a_ready(a_readyU), .busy(busyU), .done(doneU), .y(yU)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic beat_t fill(input logic [W-1:0] v);
      beat_t r;
      for (int i = 0; i < N; i++) r[i*W +: W] = v;
      return r;
   endfunction

   task automatic checkY(input string tag, input logic [N*ACC_W-1:0] yv, input logic [ACC_W-1:0] e0,
                         input logic [ACC_W-1:0] e1, input logic [ACC_W-1:0] e2, input logic [ACC_W-1:0] e3);
      logic [ACC_W-1:0] expv [N];
      expv[0] = e0; expv[1] = e1; expv[2] = e2; expv[3] = e3;
      for (int i = 0; i < N; i++)
         checkOutput($sformatf("%s_y%0d", tag, i), 64'(yv[i*ACC_W +: ACC_W]), 64'(expv[i]));
   endtask

   // Runs one computation; stalls of stallLen cycles are inserted after beat 1 is accepted.
   task automatic applyStimulus(input string tag, input beat_t xv, input beat_t beats [N], input int stallLen,
                                input bit midLoad, output int latency);
      int beatIdx   = 0;
      int stallLeft = stallLen;
      int cyc       = 0;
      bit readyOk   = 1'b1;
      latency = -1;
      @(negedge clk);
      x_init  = xv;
      load    = 1'b1;
      a_valid = 1'b0;
      @(posedge clk);
      #1;
      load = 1'b0;
      checkOutput({tag, "_busy_at_load"}, 64'(busyS), 64'd1);
      while (cyc < 40) begin
         if (beatIdx < N) begin
            readyOk = readyOk && a_readyS;
            if (beatIdx == 2 && stallLeft > 0) begin
               a_valid = 1'b0;
               stallLeft--;
            end else begin
               a_valid = 1'b1;
               a       = beats[beatIdx];
            end
            load   = midLoad;
            x_init = midLoad ? fill(16'h7777) : xv;
         end else begin
            a_valid = 1'b0;
            load    = 1'b0;
         end
         @(posedge clk);
         cyc++;
         if (a_valid) beatIdx++;
         #1;
         a_valid = 1'b0;
         load    = 1'b0;
         if (doneS) begin
            latency = cyc;
            break;
         end
      end
      checkOutput({tag, "_ready_in_run"}, 64'(readyOk), 64'd1);
      checkOutput({tag, "_busy_at_done"}, 64'(busyS), 64'd0);
   endtask

   beat_t beats [N];
   int    lat;
   int    doneSeen;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; load = 1'b0; a_valid = 1'b0; x_init = '0; a = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_y",       64'(|yS),     64'd0);
      checkOutput("rst_done",    64'(doneS),   64'd0);
      checkOutput("rst_busy",    64'(busyS),   64'd0);
      checkOutput("rst_a_ready", 64'(a_readyS), 64'd0);
      reset = 1'b0;

      // Uniform: every A element 3, x = [1,2,3,4]
      for (int k = 0; k < N; k++) beats[k] = fill(16'd3);
      applyStimulus("uniform", {16'd4, 16'd3, 16'd2, 16'd1}, beats, 0, 1'b0, lat);
      checkOutput("uniform_latency", 64'(lat), 64'd5);
      checkY("uniform", yS, 34'd30, 34'd30, 34'd30, 34'd30);
      @(posedge clk);
      #1;
      checkOutput("uniform_done_width", 64'(doneS), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkY("uniform_hold", yS, 34'd30, 34'd30, 34'd30, 34'd30);

      // Identity: diagonal beat 0 is all ones
      beats[0] = fill(16'd1);
      for (int k = 1; k < N; k++) beats[k] = fill(16'd0);
      applyStimulus("identity", {16'd4, 16'd3, 16'd2, 16'd1}, beats, 0, 1'b0, lat);
      checkY("identity", yS, 34'd1, 34'd2, 34'd3, 34'd4);

      // Stalls: two idle cycles after beat 1
      for (int k = 0; k < N; k++) beats[k] = fill(16'd3);
      applyStimulus("stall", {16'd4, 16'd3, 16'd2, 16'd1}, beats, 2, 1'b0, lat);
      checkOutput("stall_latency", 64'(lat), 64'd7);
      checkY("stall", yS, 34'd30, 34'd30, 34'd30, 34'd30);

      // Signed extremes
      for (int k = 0; k < N; k++) beats[k] = fill(16'h8000);
      applyStimulus("smin", fill(16'h8000), beats, 0, 1'b0, lat);
      checkY("smin", yS, 34'h100000000, 34'h100000000, 34'h100000000, 34'h100000000);
      for (int k = 0; k < N; k++) beats[k] = fill(16'hFFFE);
      applyStimulus("sneg", fill(16'hFFFF), beats, 0, 1'b0, lat);
      checkY("sneg", yS, 34'h8, 34'h8, 34'h8, 34'h8);

      // Unsigned maxima on the unsigned instance
      for (int k = 0; k < N; k++) beats[k] = fill(16'hFFFF);
      applyStimulus("umax", fill(16'hFFFF), beats, 0, 1'b0, lat);
      checkY("umax", yU, 34'h3FFF80004, 34'h3FFF80004, 34'h3FFF80004, 34'h3FFF80004);

      // Load pulses during RUN must be ignored
      for (int k = 0; k < N; k++) beats[k] = fill(16'd3);
      applyStimulus("midload", {16'd4, 16'd3, 16'd2, 16'd1}, beats, 0, 1'b1, lat);
      checkOutput("midload_latency", 64'(lat), 64'd5);
      checkY("midload", yS, 34'd30, 34'd30, 34'd30, 34'd30);

      // Reset after two beats: nothing published, y cleared
      @(negedge clk);
      x_init = {16'd4, 16'd3, 16'd2, 16'd1};
      load   = 1'b1;
      @(posedge clk);
      #1;
      load    = 1'b0;
      a_valid = 1'b1;
      a       = fill(16'd3);
      repeat (2) @(posedge clk);
      #1;
      a_valid = 1'b0;
      reset   = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_y",       64'(|yS),      64'd0);
      checkOutput("midrst_busy",    64'(busyS),    64'd0);
      checkOutput("midrst_a_ready", 64'(a_readyS), 64'd0);
      checkOutput("midrst_done",    64'(doneS),    64'd0);
      reset    = 1'b0;
      doneSeen = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (doneS) doneSeen++;
      end
      checkOutput("midrst_no_done", 64'(doneSeen), 64'd0);
      applyStimulus("after_rst", {16'd4, 16'd3, 16'd2, 16'd1}, beats, 0, 1'b0, lat);
      checkOutput("after_rst_latency", 64'(lat), 64'd5);
      checkY("after_rst", yS, 34'd30, 34'd30, 34'd30, 34'd30);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
